// File: rtl/axilite_reg_wr.sv
// AXI4-Lite write slave that turns each AW+W pair into one register-file write
// with wait/ack handshake and timeout, then returns a single B response.
module axilite_reg_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 40,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_wait,
  input  logic                  reg_wr_ack
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_INIT = CW'(TIMEOUT - 1);
  localparam logic [1:0]    RESP_OK  = 2'b00;
  localparam logic [1:0]    RESP_ERR = 2'b10;

  logic                  r_aw_full;
  logic                  r_w_full;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [STRB_WIDTH-1:0] r_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_wr_en;
  logic [CW-1:0]         r_cnt;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_done;
  logic w_aw_full_nxt;
  logic w_w_full_nxt;
  logic w_bvalid_nxt;
  logic w_wr_en_nxt;
  logic w_unused;

  assign w_unused = ^s_axil_awprot;

  // Ready comes straight from the slot flags, so valid never feeds ready.
  assign w_aw_hs = s_axil_awvalid & ~r_aw_full;
  assign w_w_hs  = s_axil_wvalid  & ~r_w_full;

  // Ack on the final count cycle still completes as OKAY.
  assign w_done = r_wr_en & (reg_wr_ack | (r_cnt == '0));

  always_comb begin
    w_aw_full_nxt = r_aw_full | w_aw_hs;
    w_w_full_nxt  = r_w_full  | w_w_hs;
    w_bvalid_nxt  = r_bvalid & ~s_axil_bready;
    if (w_done) begin
      w_aw_full_nxt = 1'b0;
      w_w_full_nxt  = 1'b0;
      w_bvalid_nxt  = 1'b1;
    end
    // A write pending behind an unaccepted B waits for the B handshake.
    w_wr_en_nxt = w_aw_full_nxt & w_w_full_nxt & ~w_bvalid_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_wr_en   <= 1'b0;
    end else begin
      r_aw_full <= w_aw_full_nxt;
      r_w_full  <= w_w_full_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_wr_en   <= w_wr_en_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_aw_hs) begin
      r_addr <= s_axil_awaddr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_strb <= '0;
    end else if (w_w_hs) begin
      r_data <= s_axil_wdata;
      r_strb <= s_axil_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bresp <= RESP_OK;
    end else if (w_done) begin
      r_bresp <= reg_wr_ack ? RESP_OK : RESP_ERR;
    end
  end

  // Busy cycles (wait=1) do not consume the timeout budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= CNT_INIT;
    end else if (!r_wr_en) begin
      r_cnt <= CNT_INIT;
    end else if (!reg_wr_wait && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign s_axil_awready = ~r_aw_full;
  assign s_axil_wready  = ~r_w_full;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign reg_wr_addr    = r_addr;
  assign reg_wr_data    = r_data;
  assign reg_wr_strb    = r_strb;
  assign reg_wr_en      = r_wr_en;

endmodule

// File: tb/tb_axilite_reg_wr.sv
// Bench for axilite_reg_wr: directed timing scenarios plus a randomized run,
// all writes and responses tracked by a negedge scoreboard.
module tb_axilite_reg_wr;
  localparam int DW = 32;
  localparam int AW = 40;
  localparam int SW = DW/8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s_axil_awaddr;
  logic [2:0]    s_axil_awprot;
  logic          s_axil_awvalid;
  logic          s_axil_awready;
  logic [DW-1:0] s_axil_wdata;
  logic [SW-1:0] s_axil_wstrb;
  logic          s_axil_wvalid;
  logic          s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid;
  logic          s_axil_bready;
  logic [AW-1:0] reg_wr_addr;
  logic [DW-1:0] reg_wr_data;
  logic [SW-1:0] reg_wr_strb;
  logic          reg_wr_en;
  logic          reg_wr_wait;
  logic          reg_wr_ack;

  axilite_reg_wr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int b_cnt = 0;
  bit rnd_run = 1'b0;

  logic [AW-1:0] q_aw[$];
  logic [DW-1:0] q_wd[$];
  logic [SW-1:0] q_ws[$];
  logic [1:0]    q_b[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    s_axil_awaddr  = a;
    s_axil_wdata   = d;
    s_axil_wstrb   = s;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid  = 1'b1;
  endtask

  task automatic wait_bvalid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (s_axil_bvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Scoreboard: handshakes push, register completions and B beats pop.
  task automatic monitor();
    int            tcnt;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic [1:0]    eb;
    tcnt = TO - 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        tcnt = TO - 1;
        continue;
      end
      if (s_axil_awvalid && s_axil_awready) q_aw.push_back(s_axil_awaddr);
      if (s_axil_wvalid && s_axil_wready) begin
        q_wd.push_back(s_axil_wdata);
        q_ws.push_back(s_axil_wstrb);
      end
      if (!reg_wr_en) begin
        tcnt = TO - 1;
      end else if (reg_wr_ack || tcnt == 0) begin
        n_vec++;
        if (q_aw.size() == 0 || q_wd.size() == 0) begin
          n_err++;
          $display("FAIL sb_reg_write: got write addr=%h with no issued AW/W, want none", reg_wr_addr);
        end else begin
          ea = q_aw.pop_front();
          ed = q_wd.pop_front();
          es = q_ws.pop_front();
          if ({reg_wr_addr, reg_wr_data, reg_wr_strb} !== {ea, ed, es}) begin
            n_err++;
            $display("FAIL sb_reg_write: got %h/%h/%h, want %h/%h/%h",
                     reg_wr_addr, reg_wr_data, reg_wr_strb, ea, ed, es);
          end
        end
        q_b.push_back(reg_wr_ack ? 2'b00 : 2'b10);
      end else if (!reg_wr_wait) begin
        tcnt--;
      end
      if (s_axil_bvalid && s_axil_bready) begin
        n_vec++;
        b_cnt++;
        if (q_b.size() == 0) begin
          n_err++;
          $display("FAIL sb_bresp: got B resp=%b with no completed write, want none", s_axil_bresp);
        end else begin
          eb = q_b.pop_front();
          if (s_axil_bresp !== eb) begin
            n_err++;
            $display("FAIL sb_bresp: got %b, want %b", s_axil_bresp, eb);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp, reg_wr_en} !== 6'b110000) begin
      n_err++;
      $display("FAIL reset_ctrl: got aw/w/bv/bresp/en=%b, want 110000",
               {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp, reg_wr_en});
    end
    n_vec++;
    if ({reg_wr_addr, reg_wr_data, reg_wr_strb} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h/%h/%h, want 0", reg_wr_addr, reg_wr_data, reg_wr_strb);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({s_axil_awready, s_axil_wready, reg_wr_en} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_release: got aw/w/en=%b, want 110", {s_axil_awready, s_axil_wready, reg_wr_en});
    end
  endtask

  task automatic test_single();
    reg_wr_ack = 1'b1; s_axil_bready = 1'b1;
    issue(40'h10, 32'hDEADBEEF, 4'hF);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n_vec++;
    if (reg_wr_en !== 1'b1 || reg_wr_addr !== 40'h10 || reg_wr_data !== 32'hDEADBEEF || reg_wr_strb !== 4'hF) begin
      n_err++;
      $display("FAIL single_c1: got en=%b %h/%h/%h, want 1 10/deadbeef/f",
               reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_strb);
    end
    n_vec++;
    if ({s_axil_awready, s_axil_wready, s_axil_bvalid} !== 3'b000) begin
      n_err++;
      $display("FAIL single_c1_ready: got aw/w/bv=%b, want 000", {s_axil_awready, s_axil_wready, s_axil_bvalid});
    end
    tick();
    n_vec++;
    if ({reg_wr_en, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready} !== 6'b010011) begin
      n_err++;
      $display("FAIL single_c2: got en/bv/bresp/aw/w=%b, want 010011",
               {reg_wr_en, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready});
    end
    tick();
    n_vec++;
    if ({reg_wr_en, s_axil_bvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL single_c3: got en/bv=%b, want 00", {reg_wr_en, s_axil_bvalid});
    end
  endtask

  task automatic test_skew();
    reg_wr_ack = 1'b1; s_axil_bready = 1'b1;
    s_axil_wdata = 32'h5; s_axil_wstrb = 4'h3; s_axil_wvalid = 1'b1;
    tick();
    s_axil_wvalid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_vec++;
      if ({s_axil_wready, reg_wr_en} !== 2'b00) begin
        n_err++;
        $display("FAIL skew_c%0d: got wready/en=%b, want 00", c, {s_axil_wready, reg_wr_en});
      end
      if (c == 5) begin
        s_axil_awaddr = 40'h24; s_axil_awvalid = 1'b1;
      end
      tick();
    end
    s_axil_awvalid = 1'b0;
    n_vec++;
    if ({reg_wr_en, s_axil_wready} !== 2'b10 || reg_wr_addr !== 40'h24 || reg_wr_data !== 32'h5 || reg_wr_strb !== 4'h3) begin
      n_err++;
      $display("FAIL skew_c6: got en/wready=%b %h/%h/%h, want 10 24/5/3",
               {reg_wr_en, s_axil_wready}, reg_wr_addr, reg_wr_data, reg_wr_strb);
    end
    tick();
    n_vec++;
    if ({reg_wr_en, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready} !== 6'b010011) begin
      n_err++;
      $display("FAIL skew_c7: got en/bv/bresp/aw/w=%b, want 010011",
               {reg_wr_en, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready});
    end
    tick();
  endtask

  task automatic test_timeout(input int nwait);
    int k;
    bit ok;
    reg_wr_ack = 1'b0; reg_wr_wait = 1'b0; s_axil_bready = 1'b1;
    issue(40'h40 + 40'(nwait), 32'hA5A5_0000 + 32'(nwait), 4'hC);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    k = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_axil_bvalid) begin
        ok = 1'b1;
        break;
      end
      if (reg_wr_en) begin
        k++;
        reg_wr_wait = (k <= nwait);
      end
      tick();
    end
    reg_wr_wait = 1'b0;
    n_vec++;
    if (!ok || k != TO + nwait) begin
      n_err++;
      $display("FAIL timeout_len_w%0d: got %0d en cycles (bvalid seen=%0d), want %0d", nwait, k, ok, TO + nwait);
    end
    n_vec++;
    if (s_axil_bresp !== 2'b10) begin
      n_err++;
      $display("FAIL timeout_resp_w%0d: got %b, want 10", nwait, s_axil_bresp);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    s_axil_bready = 1'b0; reg_wr_ack = 1'b0;
    issue(40'h100, 32'h1111_1111, 4'hF);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    wait_bvalid(20, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL bp_first_b: got no bvalid in 20 cycles, want bvalid");
    end
    reg_wr_ack = 1'b1;
    issue(40'h200, 32'h2222_2222, 4'h9);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if ({s_axil_bvalid, s_axil_bresp, reg_wr_en, s_axil_awready, s_axil_wready} !== 6'b110000) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got bv/bresp/en/aw/w=%b, want 110000", i,
                 {s_axil_bvalid, s_axil_bresp, reg_wr_en, s_axil_awready, s_axil_wready});
      end
      tick();
    end
    s_axil_bready = 1'b1;
    tick();
    n_vec++;
    if ({s_axil_bvalid, reg_wr_en} !== 2'b01 || reg_wr_addr !== 40'h200 || reg_wr_data !== 32'h2222_2222) begin
      n_err++;
      $display("FAIL bp_second_en: got bv/en=%b %h/%h, want 01 200/22222222",
               {s_axil_bvalid, reg_wr_en}, reg_wr_addr, reg_wr_data);
    end
    tick();
    n_vec++;
    if ({s_axil_bvalid, s_axil_bresp} !== 3'b100) begin
      n_err++;
      $display("FAIL bp_second_b: got bv/bresp=%b, want 100", {s_axil_bvalid, s_axil_bresp});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    reg_wr_ack = 1'b0; s_axil_bready = 1'b1;
    issue(40'h300, 32'h3333_3333, 4'hF);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n_vec++;
    if (reg_wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_en: got %b, want 1", reg_wr_en);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({reg_wr_en, s_axil_bvalid, s_axil_awready, s_axil_wready, s_axil_bresp} !== 6'b001100 ||
        {reg_wr_addr, reg_wr_data, reg_wr_strb} !== '0) begin
      n_err++;
      $display("FAIL rstmid_async: got en/bv/aw/w/bresp=%b %h/%h/%h, want 001100 0/0/0",
               {reg_wr_en, s_axil_bvalid, s_axil_awready, s_axil_wready, s_axil_bresp},
               reg_wr_addr, reg_wr_data, reg_wr_strb);
    end
    q_aw.delete(); q_wd.delete(); q_ws.delete(); q_b.delete();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if ({s_axil_bvalid, reg_wr_en} !== 2'b00) begin
        n_err++;
        $display("FAIL rstmid_quiet_%0d: got bv/en=%b, want 00", i, {s_axil_bvalid, reg_wr_en});
      end
    end
    reg_wr_ack = 1'b1;
    issue(40'h304, 32'h4444_4444, 4'h5);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    wait_bvalid(10, ok);
    n_vec++;
    if (!ok || s_axil_bresp !== 2'b00) begin
      n_err++;
      $display("FAIL rstmid_next: got bvalid seen=%0d bresp=%b, want 1 00", ok, s_axil_bresp);
    end
    tick();
  endtask

  task automatic test_random();
    int base;
    base = b_cnt;
    rnd_run = 1'b1;
    fork
      begin
        bit hs;
        for (int i = 0; i < 1000 && rnd_run; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          s_axil_awaddr  = {8'($urandom), 32'($urandom)};
          s_axil_awvalid = 1'b1;
          do begin
            @(negedge clk); hs = s_axil_awready; @(posedge clk); #1;
          end while (!hs && rnd_run);
          s_axil_awvalid = 1'b0;
        end
      end
      begin
        bit hs;
        for (int i = 0; i < 1000 && rnd_run; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          s_axil_wdata  = 32'($urandom);
          s_axil_wstrb  = 4'($urandom);
          s_axil_wvalid = 1'b1;
          do begin
            @(negedge clk); hs = s_axil_wready; @(posedge clk); #1;
          end while (!hs && rnd_run);
          s_axil_wvalid = 1'b0;
        end
      end
      begin
        while (rnd_run) begin
          s_axil_bready = ($urandom_range(0, 9) < 7);
          reg_wr_ack    = ($urandom_range(0, 9) < 4);
          reg_wr_wait   = ($urandom_range(0, 9) < 2);
          tick();
        end
      end
      begin
        for (int c = 0; c < 30000 && (b_cnt - base) < 1000; c++) tick();
        rnd_run = 1'b0;
      end
    join
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b1; reg_wr_ack = 1'b0; reg_wr_wait = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (b_cnt - base != 1000) begin
      n_err++;
      $display("FAIL rand_bcount: got %0d B responses, want 1000", b_cnt - base);
    end
    n_vec++;
    if (q_aw.size() + q_wd.size() + q_b.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d/%0d/%0d left in aw/w/b queues, want 0/0/0",
               q_aw.size(), q_wd.size(), q_b.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awprot = 3'b000; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0; reg_wr_wait = 1'b0; reg_wr_ack = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_skew();
    test_timeout(0);
    test_timeout(3);
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
